// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage that runs loads and stores against a
// variable-latency memory using a req/ack handshake. While an access is in
// flight it freezes the upstream pipeline with Stall and sends bubbles to
// MEM/WB. On completion it presents the result for one cycle.
// Optional build macro MEM_STAGE_TIMEOUT_EN: after TIMEOUT WAIT cycles with
// no MemAck, the access is forced to complete with 32'hDEADBEEF and the
// sticky Err flag is set.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Mvalid,
  input  logic        Mwreg,
  input  logic        Mm2reg,
  input  logic        Mwmem,
  input  logic [31:0] Malu,
  input  logic [31:0] Mb,
  input  logic [4:0]  Mrn,
  output logic        Wwreg_d,
  output logic        Wm2reg_d,
  output logic [31:0] Wmo_d,
  output logic [31:0] Walu_d,
  output logic [4:0]  Wrn_d,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic        MemAck,
  input  logic [31:0] MemRdata,
  output logic        Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        access;
  logic        is_store;
  logic        timeout_hit;
  logic [31:0] rdata_q;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT must be at least 1");
  end

  // A set load flag wins over a set store flag, so the pair counts as a load.
  assign access   = Mvalid & (Mm2reg | Mwmem);
  assign is_store = Mwmem & ~Mm2reg;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;
  logic          err_q;

  // The TIMEOUT-th WAIT cycle without ack forces completion. An ack in that
  // same cycle takes priority over the timeout.
  assign timeout_hit = (state == S_WAIT) && !MemAck && (to_cnt == CW'(TIMEOUT - 1));

  // Count consecutive WAIT cycles without ack. Clear whenever the FSM is not waiting.
  always_ff @(posedge Clk) begin
    if (Clr)
      to_cnt <= '0;
    else if (state == S_WAIT && !MemAck && !timeout_hit)
      to_cnt <= to_cnt + CW'(1);
    else
      to_cnt <= '0;
  end

  // Sticky timeout flag. Only Clr clears it.
  always_ff @(posedge Clk) begin
    if (Clr)
      err_q <= 1'b0;
    else if (timeout_hit)
      err_q <= 1'b1;
  end

  assign Err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign Err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (Clr)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic. An ack that arrives in IDLE or DONE has no effect.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (access) state_nxt = S_WAIT;
      S_WAIT:  if (MemAck || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the completion data. A store completes with zero.
  always_ff @(posedge Clk) begin
    if (Clr)
      rdata_q <= '0;
    else if (state == S_WAIT) begin
      if (MemAck)
        rdata_q <= is_store ? 32'h0 : MemRdata;
      else if (timeout_hit)
        rdata_q <= 32'hDEADBEEF;
    end
  end

  // Output decode. The M* inputs stay stable during an access, so the
  // request fields are taken straight from them and are not registered here.
  always_comb begin
    Stall    = 1'b0;
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    Wwreg_d  = 1'b0;
    Wm2reg_d = 1'b0;
    Wmo_d    = 32'h0;
    Walu_d   = 32'h0;
    Wrn_d    = 5'h0;
    case (state)
      S_IDLE: begin
        if (access) begin
          MemReq = 1'b1;
          MemWe  = is_store;
          Stall  = 1'b1;
        end else begin
          Wwreg_d = Mvalid & Mwreg;
          Walu_d  = Malu;
          Wrn_d   = Mrn;
        end
      end
      S_WAIT: begin
        MemReq = 1'b1;
        MemWe  = is_store;
        Stall  = 1'b1;
      end
      S_DONE: begin
        Wwreg_d  = Mwreg;
        Wm2reg_d = Mm2reg;
        Wmo_d    = rdata_q;
        Walu_d   = Malu;
        Wrn_d    = Mrn;
      end
      default: ;
    endcase
  end

  assign MemAddr  = MemReq ? Malu : 32'h0;
  assign MemWdata = MemReq ? Mb   : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. It drives directed and
// random instructions and computes the expected outputs for each cycle of a
// transaction. The expectations follow the instruction-level behaviour:
// pass-through, or busy for (1 + ack delay) cycles followed by one result cycle.
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        Mvalid, Mwreg, Mm2reg, Mwmem;
  logic [31:0] Malu, Mb;
  logic [4:0]  Mrn;
  logic        Wwreg_d, Wm2reg_d;
  logic [31:0] Wmo_d, Walu_d;
  logic [4:0]  Wrn_d;
  logic        Stall, MemReq, MemWe;
  logic [31:0] MemAddr, MemWdata;
  logic        MemAck;
  logic [31:0] MemRdata;
  logic        Err;

  int tests = 0;
  int fails = 0;
  logic exp_err = 1'b0;

  mem_stage #(.TIMEOUT(16)) dut (
    .Clk(Clk), .Clr(Clr),
    .Mvalid(Mvalid), .Mwreg(Mwreg), .Mm2reg(Mm2reg), .Mwmem(Mwmem),
    .Malu(Malu), .Mb(Mb), .Mrn(Mrn),
    .Wwreg_d(Wwreg_d), .Wm2reg_d(Wm2reg_d), .Wmo_d(Wmo_d), .Walu_d(Walu_d), .Wrn_d(Wrn_d),
    .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemAck(MemAck), .MemRdata(MemRdata), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic stall, input logic req,
                            input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic wwreg, input logic wm2reg, input logic [31:0] wmo,
                            input logic [31:0] walu, input logic [4:0] wrn);
    check({tag, ".Stall"},    {31'b0, Stall},    {31'b0, stall});
    check({tag, ".MemReq"},   {31'b0, MemReq},   {31'b0, req});
    check({tag, ".MemWe"},    {31'b0, MemWe},    {31'b0, we});
    check({tag, ".MemAddr"},  MemAddr,           addr);
    check({tag, ".MemWdata"}, MemWdata,          wdata);
    check({tag, ".Wwreg_d"},  {31'b0, Wwreg_d},  {31'b0, wwreg});
    check({tag, ".Wm2reg_d"}, {31'b0, Wm2reg_d}, {31'b0, wm2reg});
    check({tag, ".Wmo_d"},    Wmo_d,             wmo);
    check({tag, ".Walu_d"},   Walu_d,            walu);
    check({tag, ".Wrn_d"},    {27'b0, Wrn_d},    {27'b0, wrn});
    check({tag, ".Err"},      {31'b0, Err},      {31'b0, exp_err});
  endtask

  // One instruction through the stage. ack_dly is the WAIT cycle (1-based)
  // in which MemAck pulses. ack_idle additionally raises MemAck during the
  // IDLE cycle, which the stage must ignore.
  task automatic run_op(input string tag, input logic v, input logic wreg, input logic m2reg,
                        input logic wmem, input logic [31:0] alu, input logic [31:0] b,
                        input logic [4:0] rn, input int ack_dly, input logic [31:0] rdata,
                        input logic ack_idle);
    logic acc, st;
    logic [31:0] mo;
    acc = v & (m2reg | wmem);
    st  = wmem & ~m2reg;
    mo  = st ? 32'h0 : rdata;
    Mvalid = v; Mwreg = wreg; Mm2reg = m2reg; Mwmem = wmem;
    Malu = alu; Mb = b; Mrn = rn;
    MemAck = ack_idle; MemRdata = $urandom;
    @(negedge Clk);
    if (!acc) begin
      check_outs({tag, ".pass"}, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, v & wreg, 1'b0, 32'h0, alu, rn);
      @(posedge Clk); #1;
      return;
    end
    check_outs({tag, ".req"}, 1'b1, 1'b1, st, alu, b, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    for (int k = 1; k <= ack_dly; k++) begin
      @(posedge Clk); #1;
      MemAck   = (k == ack_dly);
      MemRdata = (k == ack_dly) ? rdata : $urandom;
      @(negedge Clk);
      check_outs({tag, ".wait"}, 1'b1, 1'b1, st, alu, b, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    end
    @(posedge Clk); #1;
    MemAck = 1'b0;
    @(negedge Clk);
    check_outs({tag, ".done"}, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, wreg, m2reg, mo, alu, rn);
    @(posedge Clk); #1;
  endtask

  initial begin
    Clr = 1'b1; Mvalid = 0; Mwreg = 0; Mm2reg = 0; Mwmem = 0;
    Malu = 0; Mb = 0; Mrn = 0; MemAck = 0; MemRdata = 0;
    @(posedge Clk); @(posedge Clk); #1;
    Clr = 1'b0;
    @(negedge Clk);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    @(posedge Clk); #1;

    // Directed cases.
    run_op("add",   1, 1, 0, 0, 32'h10,  32'h0,    5'd5, 1, 32'h0,        0);
    run_op("load",  1, 1, 1, 0, 32'h100, 32'h0,    5'd7, 1, 32'hCAFEF00D, 0);
    run_op("store", 1, 0, 0, 1, 32'h40,  32'h1234, 5'd0, 3, 32'h55AA55AA, 0);
    run_op("ldst",  1, 1, 1, 1, 32'h80,  32'h99,   5'd3, 2, 32'h0BADF00D, 1);
    run_op("inval", 0, 1, 1, 1, 32'h44,  32'h99,   5'd9, 1, 32'h0,        0);
    run_op("ackidle", 1, 1, 1, 0, 32'h8, 32'h0,    5'd1, 2, 32'h12345678, 1);

    // Clear in the middle of WAIT, then a late ack that must be ignored.
    Mvalid = 1; Mwreg = 1; Mm2reg = 1; Mwmem = 0; Malu = 32'h200; Mrn = 5'd4; MemAck = 0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Clr = 1'b1;
    @(posedge Clk); #1;
    Clr = 1'b0; Mvalid = 0; Mm2reg = 0; Mwreg = 0; MemAck = 1; MemRdata = 32'hFFFF0000;
    @(negedge Clk);
    check_outs("clrwait", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h200, 5'd4);
    @(posedge Clk); #1;
    MemAck = 0;
    @(negedge Clk);
    check_outs("clrwait2", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h200, 5'd4);
    @(posedge Clk); #1;

`ifdef MEM_STAGE_TIMEOUT_EN
    // No ack: sixteen WAIT cycles, forced completion, and a sticky Err.
    Mvalid = 1; Mwreg = 1; Mm2reg = 1; Mwmem = 0; Malu = 32'h300; Mb = 0; Mrn = 5'd6; MemAck = 0;
    @(negedge Clk);
    check_outs("to.req", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      check_outs("to.wait", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    end
    @(posedge Clk); #1;
    exp_err = 1'b1;
    @(negedge Clk);
    check_outs("to.done", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h300, 5'd6);
    @(posedge Clk); #1;
    run_op("to.after", 1, 1, 1, 0, 32'h304, 32'h0, 5'd2, 2, 32'h1111, 0);
    Clr = 1'b1; Mvalid = 0;
    @(posedge Clk); #1;
    Clr = 1'b0; exp_err = 1'b0;
    @(negedge Clk);
    check("to.clr.Err", {31'b0, Err}, 32'h0);
    @(posedge Clk); #1;
`else
    // Without the timeout option the stage waits for as long as needed.
    run_op("longwait", 1, 1, 1, 0, 32'h300, 32'h0, 5'd6, 40, 32'h87654321, 0);
`endif

    // Random instruction mix with ack delays of 1 to 4 cycles.
    for (int n = 0; n < 60; n++) begin
      run_op("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, 5'($urandom), int'($urandom_range(1, 4)), $urandom,
             1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
